// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : aes_pkg                                                |
// | Description : Shared types, mode encodings and GF(2^8) helpers for   |
// |               the AES round controller and its round datapath.       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } rc_state_t;

  localparam logic [1:0] RD_MODE_NORMAL = 2'b00;
  localparam logic [1:0] RD_MODE_FINAL  = 2'b01;

  localparam int AES128_ROUNDS = 10;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add form.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box computed as multiplicative inverse (x^254, so 0 maps to 0)
  // followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // MixColumns on one column; the top byte is row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_rounddata.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : aes_rounddata                                          |
// | Description : Combinational AES encryption round. Round 0 performs   |
// |               only AddRoundKey (whitening); other rounds perform     |
// |               SubBytes, ShiftRows, MixColumns (skipped in final      |
// |               mode) and AddRoundKey.                                 |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module aes_rounddata
  import aes_pkg::*;
(
  input  logic [3:0]   round,
  input  logic [1:0]   mode,
  input  logic [127:0] data_in,
  input  logic [127:0] round_key,
  output logic [127:0] data_out
);

  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;

  // Byte i of the block sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign sub_bytes[127-8*i -: 8] = sbox(data_in[127-8*i -: 8]);
  end

  // ShiftRows, MixColumns and the final key addition for the selected round type.
  always_comb begin
    shifted = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
    if (round == 4'd0) begin
      data_out = data_in ^ round_key;
    end else if (mode == RD_MODE_FINAL) begin
      data_out = shifted ^ round_key;
    end else begin
      data_out = mixed ^ round_key;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : aes_round_ctrl                                         |
// | Description : Sequences one aes_rounddata instance through a full    |
// |               AES encryption of a single 128-bit block, fetching     |
// |               round keys 0..NUM_ROUNDS over a req/valid interface.   |
// | Options     : AES_RC_CYCLE_CNT_EN adds the cycle_cnt output, which   |
// |               counts INIT/ROUND cycles of the current block.         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         rk_req,
  output logic [3:0]   rk_round,
  input  logic         rk_valid,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_RC_CYCLE_CNT_EN
  ,
  output logic [15:0]  cycle_cnt
`endif
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_rounds
    $error("aes_round_ctrl: NUM_ROUNDS must be 10, 12 or 14");
  end

  rc_state_t    st, st_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [127:0] state, state_nxt;
  logic [1:0]   mode;
  logic [127:0] rd_out;

  // The plaintext is captured into the state register on accept, so INIT
  // is simply round 0 of the datapath (whitening) applied to that register.
  assign mode = (st == ROUND && rnd == LAST_RND) ? RD_MODE_FINAL : RD_MODE_NORMAL;

  aes_rounddata u_rounddata (
    .round     (rnd),
    .mode      (mode),
    .data_in   (state),
    .round_key (rk_data),
    .data_out  (rd_out)
  );

  // State register, round counter and block state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      rnd   <= 4'd0;
      state <= '0;
    end else begin
      st    <= st_nxt;
      rnd   <= rnd_nxt;
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; a missing key simply holds everything.
  always_comb begin
    st_nxt    = st;
    rnd_nxt   = rnd;
    state_nxt = state;
    in_ready  = 1'b0;
    rk_req    = 1'b0;
    rk_round  = 4'd0;
    out_valid = 1'b0;
    out_data  = '0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = in_data;
          rnd_nxt   = 4'd0;
          st_nxt    = INIT;
        end
      end
      INIT: begin
        rk_req   = 1'b1;
        rk_round = 4'd0;
        if (rk_valid) begin
          state_nxt = rd_out;
          rnd_nxt   = 4'd1;
          st_nxt    = ROUND;
        end
      end
      ROUND: begin
        rk_req   = 1'b1;
        rk_round = rnd;
        if (rk_valid) begin
          state_nxt = rd_out;
          if (rnd == LAST_RND) begin
            rnd_nxt = 4'd0;
            st_nxt  = DONE;
          end else begin
            rnd_nxt = rnd + 4'd1;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = state;
        if (out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

`ifdef AES_RC_CYCLE_CNT_EN
  logic [15:0] cnt;

  // Busy-cycle counter: cleared on accept, saturating count of INIT/ROUND cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (st == IDLE && in_valid) begin
      cnt <= 16'd0;
    end else if ((st == INIT || st == ROUND) && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign cycle_cnt = cnt;
`endif

endmodule
`default_nettype wire
